haraka_seq: RTL and testbench

Multi-cycle sequencer that drives the combinational `haraka_core` round datapath. It accepts a Haraka-256 or Haraka-512 message and steps the core through 5 rounds × 2 AES sub-rounds, applying the lane mix after each round. It finishes with the feed-forward XOR and, in 512 mode, truncation to a 256-bit digest. It sits between the SPHINCS+ hash front-end (thash/PRF) and `haraka_core`, and acts as the initiator on the core's round interface.

---
 rtl/haraka_seq.sv | 139 +++++++++++++
 tb/tb_haraka_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/haraka_seq.sv
// haraka_seq: steps an external combinational haraka_core through 5 rounds x 2 AES
//   sub-rounds, applying the lane mix after each round. It then applies the
//   feed-forward XOR and, in Haraka-512 mode, truncates the result to a 256-bit digest.
// Latency: 10 RUN cycles after the input handshake. out_valid is high in the cycle after the
//   last RUN edge. One hash is accepted every 12 cycles at best.
// Backpressure: DONE holds digest_out/out_valid until out_ready. in_valid is ignored
//   outside IDLE, and nothing is queued.
// Ports: CLK/RESET (sync, active-high); in_valid/in_ready/mode/msg_in (message in);
//   out_valid/out_ready/digest_out (digest out); core_* (round interface to haraka_core).
module haraka_seq (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [511:0] msg_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out,
  output logic         core_hara_c,
  output logic [255:0] core_block_1,
  output logic [255:0] core_block_2,
  output logic [3:0]   core_round,
  output logic [1:0]   core_round_aes,
  input  logic [255:0] core_new_block_1,
  input  logic [255:0] core_new_block_2
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [511:0] st_q, st_d;
  logic [511:0] m_q, m_d;
  logic         mode_q, mode_d;
  logic [2:0]   r_q, r_d;
  logic         a_q, a_d;

  logic [511:0] nxt;
  logic [511:0] msg_masked;
  logic [511:0] ff;

  // Interleave the 32-bit words of a 256-bit half: w1..w8 -> w1,w5,w2,w6,w3,w7,w4,w8.
  function automatic logic [255:0] mix256(input logic [255:0] x);
    return {x[255:224], x[127:96], x[223:192], x[95:64],
            x[191:160], x[63:32],  x[159:128], x[31:0]};
  endfunction

  // 512-bit lane mix: w1..w16 -> w4,w12,w8,w16,w9,w1,w13,w5,w10,w2,w14,w6,w3,w11,w7,w15.
  function automatic logic [511:0] mix512(input logic [511:0] x);
    return {x[415:384], x[159:128], x[287:256], x[31:0],
            x[255:224], x[511:480], x[127:96],  x[383:352],
            x[223:192], x[479:448], x[95:64],   x[351:320],
            x[447:416], x[191:160], x[319:288], x[63:32]};
  endfunction

  assign nxt        = {core_new_block_1, core_new_block_2};
  // In 256 mode the lower half of the message never enters the state or the feed-forward.
  assign msg_masked = mode ? msg_in : {msg_in[511:256], 256'd0};

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    m_d     = m_q;
    mode_d  = mode_q;
    r_d     = r_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = msg_masked;
          m_d     = msg_masked;
          mode_d  = mode;
          r_d     = 3'd0;
          a_d     = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!a_q) begin
          st_d = nxt;
          a_d  = 1'b1;
        end else begin
          st_d = mode_q ? mix512(nxt) : {mix256(nxt[511:256]), 256'd0};
          a_d  = 1'b0;
          if (r_q == 3'd4) begin
            r_d     = 3'd0;
            state_d = S_DONE;
          end else begin
            r_d = r_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      m_q     <= '0;
      mode_q  <= 1'b0;
      r_q     <= 3'd0;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      m_q     <= m_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      a_q     <= a_d;
    end
  end

  // Readiness depends only on the state flop. It is gated by RESET so that it reads 0
  // while reset is held.
  assign in_ready  = (state_q == S_IDLE) && !RESET;
  assign out_valid = (state_q == S_DONE);

  assign ff = st_q ^ m_q;
  always_comb begin
    digest_out = '0;
    if (state_q == S_DONE) begin
      digest_out = mode_q ? {ff[447:384], ff[319:256], ff[255:192], ff[127:64]}
                          : ff[511:256];
    end
  end

  // The core sees zeros outside RUN, so it stays quiet between hashes.
  assign core_hara_c    = mode_q;
  assign core_block_1   = (state_q == S_RUN) ? st_q[511:256] : '0;
  assign core_block_2   = (state_q == S_RUN) ? st_q[255:0]   : '0;
  assign core_round     = (state_q == S_RUN) ? {1'b0, r_q}   : 4'd0;
  assign core_round_aes = (state_q == S_RUN) ? {1'b0, a_q}   : 2'd0;

endmodule

// File: tb/tb_haraka_seq.sv
// Testbench for haraka_seq. A keyed, round-dependent permutation stands in for haraka_core,
// so sequencing, masking, the mixes, feed-forward and truncation are all visible in the digest.
module tb_haraka_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         mode_i;
  logic [511:0] msg_i;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest_out;
  logic         core_hara_c;
  logic [255:0] core_block_1, core_block_2;
  logic [3:0]   core_round;
  logic [1:0]   core_round_aes;
  logic [255:0] core_nb1, core_nb2;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  haraka_seq dut (
    .CLK(clk), .RESET(reset),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode_i), .msg_in(msg_i),
    .out_valid(out_valid), .out_ready(out_ready), .digest_out(digest_out),
    .core_hara_c(core_hara_c), .core_block_1(core_block_1), .core_block_2(core_block_2),
    .core_round(core_round), .core_round_aes(core_round_aes),
    .core_new_block_1(core_nb1), .core_new_block_2(core_nb2)
  );

  // Stand-in core: byte-rotate across the two halves and XOR a key built from round/sub-round/mode.
  function automatic logic [511:0] core_fn(input logic [255:0] b1, input logic [255:0] b2,
                                           input logic [3:0] r, input logic [1:0] a, input logic c);
    logic [7:0]   k8;
    logic [255:0] k;
    k8 = {r, a, c, 1'b1};
    k  = {32{k8}};
    return {({b1[247:0], b2[255:248]} ^ k), ({b2[247:0], b1[255:248]} ^ ~k)};
  endfunction

  always_comb {core_nb1, core_nb2} = core_fn(core_block_1, core_block_2, core_round, core_round_aes, core_hara_c);

  function automatic logic [255:0] ref_mix256(input logic [255:0] x);
    logic [255:0] y;
    for (int k = 0; k < 4; k++) begin
      y[255-64*k -: 32] = x[255-32*k -: 32];
      y[223-64*k -: 32] = x[255-32*(k+4) -: 32];
    end
    return y;
  endfunction

  function automatic logic [511:0] ref_mix512(input logic [511:0] x);
    int p [16];
    logic [511:0] y;
    p = '{3, 11, 7, 15, 8, 0, 12, 4, 9, 1, 13, 5, 2, 10, 6, 14};
    for (int k = 0; k < 16; k++) y[511-32*k -: 32] = x[511-32*p[k] -: 32];
    return y;
  endfunction

  function automatic logic [255:0] ref_digest(input logic md, input logic [511:0] msg);
    logic [511:0] s, m, n, f;
    s = md ? msg : {msg[511:256], 256'd0};
    m = s;
    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 2; a++) begin
        n = core_fn(s[511:256], s[255:0], 4'(r), 2'(a), md);
        if (a == 0)  s = n;
        else if (md) s = ref_mix512(n);
        else         s = {ref_mix256(n[511:256]), 256'd0};
      end
    end
    f = s ^ m;
    return md ? {f[447:384], f[319:256], f[255:192], f[127:64]} : f[511:256];
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One hash with out_ready held high: checks the round sequence, latency, digest and return to IDLE.
  task automatic hash_one(input string name, input logic md, input logic [511:0] msg,
                          input logic [255:0] exp);
    int w;
    int lat;
    logic seq_ok;
    @(negedge clk);
    mode_i = md; msg_i = msg; in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 30) begin @(negedge clk); w++; end
    chk({name, "_accept"}, 256'(in_ready), 256'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; seq_ok = 1'b1;
    while (!out_valid && lat < 30) begin
      if (core_round != 4'((lat-1)/2) || core_round_aes != 2'((lat-1)%2) || core_hara_c != md)
        seq_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 256'(lat), 256'd11);
    chk({name, "_roundseq"}, 256'(seq_ok), 256'd1);
    chk({name, "_digest"}, digest_out, exp);
    @(negedge clk);
    chk({name, "_idle"}, 256'({in_ready, out_valid}), 256'b10);
  endtask

  typedef struct {
    string        name;
    logic         md;
    logic [511:0] msg;
    logic [255:0] exp;
  } vec_t;

  vec_t         tbl [5];
  logic [511:0] asc;
  logic [255:0] d0;
  logic         stable;
  int           w;
  int           t_prev;
  logic         bb_md [4];
  logic [511:0] bb_msg [4];

  initial begin
    reset = 1'b1; in_valid = 1'b0; mode_i = 1'b0; msg_i = '0; out_ready = 1'b0;

    for (int i = 0; i < 64; i++) asc[511-8*i -: 8] = 8'(i);
    tbl[0] = '{"h256_asc",   1'b0, asc,                          ref_digest(1'b0, asc)};
    tbl[1] = '{"h512_asc",   1'b1, asc,                          ref_digest(1'b1, asc)};
    // The lower half is all ones but must be masked, so the expected digest is the all-zero one.
    tbl[2] = '{"h256_mask",  1'b0, {256'd0, {256{1'b1}}},        ref_digest(1'b0, 512'd0)};
    tbl[3] = '{"h512_ones",  1'b1, {512{1'b1}},                  ref_digest(1'b1, {512{1'b1}})};
    tbl[4] = '{"h256_zero",  1'b0, 512'd0,                       ref_digest(1'b0, 512'd0)};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  256'(in_ready), 256'd0);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_digest",    digest_out, 256'd0);
    chk("rst_core",      {core_block_1 | core_block_2, 186'd0, core_round, core_round_aes, core_hara_c}, 256'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_idle_ready", 256'(in_ready), 256'd1);

    // Table-driven vectors.
    for (int i = 0; i < 5; i++) hash_one(tbl[i].name, tbl[i].md, tbl[i].msg, tbl[i].exp);

    // Backpressure: hold out_ready low for 20 cycles while offering another message.
    @(negedge clk);
    mode_i = 1'b1; msg_i = ~asc; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 30) begin @(negedge clk); w++; end
    chk("bp_valid", 256'(out_valid), 256'd1);
    d0 = digest_out;
    chk("bp_digest", d0, ref_digest(1'b1, ~asc));
    in_valid = 1'b1; mode_i = 1'b0; msg_i = asc;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (digest_out !== d0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 256'(stable), 256'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 256'({in_ready, out_valid}), 256'b10);
    hash_one("bp_second", 1'b0, asc, ref_digest(1'b0, asc));

    // Back-to-back: in_valid and out_ready held high with four alternating messages.
    bb_md[0] = 1'b0; bb_msg[0] = asc;
    bb_md[1] = 1'b1; bb_msg[1] = {asc[255:0], asc[511:256]};
    bb_md[2] = 1'b0; bb_msg[2] = ~asc;
    bb_md[3] = 1'b1; bb_msg[3] = asc ^ {64{8'h5a}};
    @(negedge clk);
    mode_i = bb_md[0]; msg_i = bb_msg[0]; in_valid = 1'b1; out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      while (!in_ready && w < 30) begin @(negedge clk); w++; end
      @(negedge clk);
      if (i < 3) begin mode_i = bb_md[i+1]; msg_i = bb_msg[i+1]; end
      else in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 30) begin @(negedge clk); w++; end
      chk($sformatf("b2b%0d_digest", i), digest_out, ref_digest(bb_md[i], bb_msg[i]));
      if (i > 0) chk($sformatf("b2b%0d_spacing", i), 256'(cyc - t_prev), 256'd12);
      t_prev = cyc;
      @(negedge clk);
    end

    // Reset in the middle of RUN at r=2, a=1.
    @(negedge clk);
    mode_i = 1'b1; msg_i = {512{1'b1}}; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pos", 256'({core_round, core_round_aes}), 256'({4'd2, 2'd1}));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_quiet", {core_block_1 | core_block_2, 185'd0, core_round, core_round_aes, core_hara_c, out_valid, in_ready}, 256'd0);
    reset = 1'b0;
    #1;
    chk("abort_idle", 256'(in_ready), 256'd1);
    hash_one("abort_next", 1'b0, asc, ref_digest(1'b0, asc));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    nfail++;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $fatal(1, "timeout");
  end

endmodule
